// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: FIFO controller around an external dual-port BRAM with 1-cycle registered read
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] din_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] dout_b
);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   pending;
  logic                  push, pop, issue;
  assign s_ready = count != DEPTH;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign pending = count - (ADDR_WIDTH+1)'(m_valid);
  assign issue   = pending != '0 && (!m_valid || m_ready);
  assign we_a    = push && !rst;
  assign addr_a  = wr_ptr;
  assign din_a   = s_data;
  assign we_b    = 1'b0;
  assign addr_b  = issue ? rd_ptr : rd_ptr - 1'b1;
  assign m_data  = dout_b;
  // pointer, occupancy and output-valid bookkeeping; a stalled word stays counted until popped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr  <= rd_ptr + ADDR_WIDTH'(issue);
      count   <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      m_valid <= issue ? 1'b1 : pop ? 1'b0 : m_valid;
    end
  end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed and random checks of bram_fifo_ctrl against a queue-based reference
module tb_bram_fifo_ctrl;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0, m_data, din_a, dout_b;
  logic s_ready, m_valid, we_a, we_b;
  logic [2:0] count;
  logic [1:0] addr_a, addr_b;
  logic [7:0] mem [4];
  logic [7:0] q[$];
  logic mv;
  int pushed, popped, tests, fails;

  bram_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
    .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .we_b(we_b), .addr_b(addr_b), .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    dout_b <= mem[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic [7:0] sd, input logic mr);
    logic ep, eo, iss;
    int pend;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    ep = !r && sv && q.size() < 4;
    eo = mv && mr;
    check("count", 32'(count), q.size());
    check("s_ready", 32'(s_ready), 32'(q.size() < 4));
    check("m_valid", 32'(m_valid), 32'(mv));
    check("we_a", 32'(we_a), 32'(ep));
    check("we_b", 32'(we_b), 0);
    if (mv) check("m_data", 32'(m_data), 32'(q[0]));
    if (ep) check("addr_a", 32'(addr_a), pushed % 4);
    if (mv && !mr) check("addr_b_hold", 32'(addr_b), popped % 4);
    pend = q.size() - int'(mv);
    iss = pend > 0 && (!mv || mr);
    @(posedge clk);
    if (r) begin
      q.delete(); mv = 1'b0; pushed = 0; popped = 0;
    end else begin
      if (eo) begin void'(q.pop_front()); popped++; end
      if (ep) begin q.push_back(sd); pushed++; end
      mv = iss ? 1'b1 : eo ? 1'b0 : mv;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    repeat (2) @(posedge clk);
    q.delete(); mv = 1'b0; pushed = 0; popped = 0;
    step(0, 1, 8'h11, 1);
    repeat (3) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hA0 + 8'(i), 0);
    step(0, 1, 8'hA4, 0);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'hB0 + 8'(i), 1);
    repeat (4) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 8'hC0 + 8'(i), 1);
    repeat (4) step(0, 0, 8'h00, 1);
    step(0, 1, 8'hD0, 1);
    step(0, 1, 8'hD1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hD2 + 8'(i), 0);
    repeat (6) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 8'hE0 + 8'(i), 0);
    step(0, 0, 8'h00, 0);
    step(1, 1, 8'hEE, 0);
    step(0, 1, 8'h5A, 1);
    repeat (3) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    repeat (6) step(0, 0, 8'h00, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
